// File: rtl/data_mem_ctrl_if.sv
// Word-bus interface between data_mem_ctrl (master) and a data memory (slave).
// Latency: none, wires only. Backpressure: the slave stretches an access by delaying bus_ack.
// Ports: bus_req/bus_we/bus_addr/bus_be/bus_wdata from master; bus_rdata/bus_ack from slave.
interface data_mem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller: turns one MEM-stage load/store into one big-endian word-bus access.
// Latency: access in cycle 0, bus_req from cycle 1, ack in cycle k gives DONE in cycle k+1.
// Backpressure: stall holds the pipeline from the access cycle until the bus acks or times out.
// Ports: clk, reset (sync, active-high); cpu_* request side with cpu_rdata/stall/misalign/bus_err
//   status; bus is the master side of data_mem_ctrl_if.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_rd,
  input  logic            cpu_wr,
  input  logic            cpu_sb,
  input  logic            cpu_sh,
  input  logic [31:0]     cpu_addr,
  input  logic [31:0]     cpu_wdata,
  output logic [31:0]     cpu_rdata,
  output logic            stall,
  output logic            misalign,
  output logic            bus_err,
  data_mem_ctrl_if.master bus
);

  // The counter only has to reach TIMEOUT-1.
  localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misalign_q, misalign_d;
  logic          err_q, err_d;

  logic          access;
  logic          bad;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;

  // Lane selection: offset 0 lives in bits [31:24]. Byte/halfword qualifiers only
  // matter for stores; sb beats sh when both are set.
  always_comb begin
    access    = cpu_rd | cpu_wr;
    bad       = cpu_wr & cpu_sh & cpu_addr[0];
    be_new    = 4'b1111;
    wdata_new = cpu_wdata;
    if (cpu_wr && cpu_sb) begin
      be_new    = 4'b1000 >> cpu_addr[1:0];
      wdata_new = {4{cpu_wdata[7:0]}};
    end else if (cpu_wr && cpu_sh) begin
      be_new    = cpu_addr[1] ? 4'b0011 : 4'b1100;
      wdata_new = {2{cpu_wdata[15:0]}};
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    err_d      = 1'b0;
    stall      = 1'b0;

    case (state_q)
      IDLE: begin
        if (access && !bad) begin
          stall   = 1'b1;
          state_d = BUSY;
          req_d   = 1'b1;
          count_d = '0;
          we_d    = cpu_wr;
          addr_d  = {cpu_addr[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
        end else if (access && bad) begin
          misalign_d = 1'b1;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        count_d = count_q + CW'(1);
        // An ack arriving in the timeout cycle still completes normally.
        if (bus.bus_ack) begin
          if (!we_q) rdata_d = bus.bus_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (count_q == LAST) begin
          if (!we_q) rdata_d = 32'hFFFF_FFFF;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // The finished access is still on cpu_* this cycle; do not re-issue it.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  assign cpu_rdata     = rdata_q;
  assign misalign      = misalign_q;
  assign bus_err       = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, hand-written corner
// sequences (misalign, reset mid-access, stray ack) and randomized accesses vs a model.
module tb_data_mem_ctrl;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr, cpu_sb, cpu_sh;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall, misalign, bus_err;

  data_mem_ctrl_if bif ();

  data_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_sb    (cpu_sb),
    .cpu_sh    (cpu_sh),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus       (bif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, sb, sh;
    logic [31:0] addr, wdata;
    int          ack_at;     // cycle (0 = access cycle) in which bus_ack pulses
    logic [31:0] resp;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    int          e_stall;
    logic        e_err;
    logic [31:0] e_rdata;    // only meaningful for reads
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_rdata;
  vec_t        tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_sb = 0; cpu_sh = 0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Expected results computed from the access rules directly.
  function automatic vec_t model(input vec_t v, input logic [31:0] last);
    vec_t r = v;
    int   off = int'(v.addr[1:0]);
    bit   acked = (v.ack_at >= 1) && (v.ack_at <= TIMEOUT);
    r.e_addr  = v.addr & 32'hFFFF_FFFC;
    r.e_we    = v.wr;
    r.e_be    = 4'hF;
    r.e_wdata = v.wdata;
    if (v.wr && v.sb) begin
      r.e_be    = 4'(1 << (3 - off));
      r.e_wdata = 32'(v.wdata[7:0]) * 32'h0101_0101;
    end else if (v.wr && v.sh) begin
      r.e_be    = (off < 2) ? 4'hC : 4'h3;
      r.e_wdata = 32'(v.wdata[15:0]) * 32'h0001_0001;
    end
    r.e_stall = (acked ? v.ack_at : TIMEOUT) + 1;
    r.e_err   = !acked;
    r.e_rdata = v.wr ? last : (acked ? v.resp : 32'hFFFF_FFFF);
    return r;
  endfunction

  task automatic run_access(input string nm, input vec_t v);
    int   stall_cnt = 0;
    bit   done = 0;
    logic read_op = v.rd & ~v.wr;
    cpu_rd = v.rd; cpu_wr = v.wr; cpu_sb = v.sb; cpu_sh = v.sh;
    cpu_addr = v.addr; cpu_wdata = v.wdata;
    for (int cyc = 0; cyc < TIMEOUT + 4 && !done; cyc++) begin
      bif.bus_ack   = (cyc == v.ack_at);
      bif.bus_rdata = bif.bus_ack ? v.resp : $urandom;
      @(negedge clk);
      if (cyc == 1) begin
        chk({nm, " bus_req"},   32'(bif.bus_req), 32'h1);
        chk({nm, " bus_addr"},  bif.bus_addr,     v.e_addr);
        chk({nm, " bus_be"},    32'(bif.bus_be),  32'(v.e_be));
        chk({nm, " bus_we"},    32'(bif.bus_we),  32'(v.e_we));
        chk({nm, " bus_wdata"}, bif.bus_wdata,    v.e_wdata);
      end
      if (stall) stall_cnt++;
      else begin
        done = 1;
        chk({nm, " stall_cycles"}, 32'(stall_cnt), 32'(v.e_stall));
        chk({nm, " bus_err"},      32'(bus_err),   32'(v.e_err));
        chk({nm, " done_req"},     32'(bif.bus_req), 32'h0);
        if (read_op) last_rdata = v.e_rdata;
        chk({nm, " cpu_rdata"},    cpu_rdata,      last_rdata);
      end
      next_cycle();
    end
    bif.bus_ack = 0;
    idle_inputs();
    if (!done) chk({nm, " completion_timeout"}, 32'h0, 32'h1);
    @(negedge clk);
    chk({nm, " err_pulse_end"}, 32'(bus_err), 32'h0);
    chk({nm, " idle_stall"},    32'(stall),   32'h0);
    next_cycle();
  endtask

  task automatic run_misalign(input string nm, input logic [31:0] addr);
    cpu_wr = 1; cpu_sh = 1; cpu_addr = addr; cpu_wdata = $urandom;
    @(negedge clk);
    chk({nm, " stall"}, 32'(stall), 32'h0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk({nm, " misalign"}, 32'(misalign),    32'h1);
    chk({nm, " no_req"},   32'(bif.bus_req), 32'h0);
    next_cycle();
    @(negedge clk);
    chk({nm, " pulse_end"}, 32'(misalign),   32'h0);
    chk({nm, " no_req2"},   32'(bif.bus_req), 32'h0);
    next_cycle();
  endtask

  initial begin
    //          rd wr sb sh addr          wdata         ack resp          be    e_addr        e_wdata       we stall err rdata
    tbl[0]  = '{0, 1, 0, 0, 32'h104,      32'hA1B2C3D4, 1,  32'h0,        4'hF, 32'h104,      32'hA1B2C3D4, 1, 2,  0, 32'h0};
    tbl[1]  = '{0, 1, 1, 0, 32'h203,      32'h00000055, 2,  32'h0,        4'h1, 32'h200,      32'h55555555, 1, 3,  0, 32'h0};
    tbl[2]  = '{0, 1, 0, 1, 32'h202,      32'h00001234, 1,  32'h0,        4'h3, 32'h200,      32'h12341234, 1, 2,  0, 32'h0};
    tbl[3]  = '{1, 0, 0, 0, 32'h40,       32'h11111111, 5,  32'hCAFEF00D, 4'hF, 32'h40,       32'h11111111, 0, 6,  0, 32'hCAFEF00D};
    tbl[4]  = '{1, 0, 0, 0, 32'h44,       32'h0,        0,  32'h0,        4'hF, 32'h44,       32'h0,        0, 16, 1, 32'hFFFFFFFF};
    tbl[5]  = '{1, 0, 0, 0, 32'h48,       32'h0,        15, 32'h12345678, 4'hF, 32'h48,       32'h0,        0, 16, 0, 32'h12345678};
    tbl[6]  = '{0, 1, 1, 0, 32'h101,      32'h000000AB, 3,  32'h0,        4'h4, 32'h100,      32'hABABABAB, 1, 4,  0, 32'h0};
    tbl[7]  = '{0, 1, 1, 1, 32'h102,      32'h001234CD, 1,  32'h0,        4'h2, 32'h100,      32'hCDCDCDCD, 1, 2,  0, 32'h0};
    tbl[8]  = '{1, 1, 0, 0, 32'h10C,      32'h87654321, 2,  32'h5A5A5A5A, 4'hF, 32'h10C,      32'h87654321, 1, 3,  0, 32'h0};
    tbl[9]  = '{0, 1, 0, 1, 32'h200,      32'h0000BEEF, 1,  32'h0,        4'hC, 32'h200,      32'hBEEFBEEF, 1, 2,  0, 32'h0};
    tbl[10] = '{1, 0, 0, 0, 32'h7,        32'h0,        16, 32'h0BADF00D, 4'hF, 32'h4,        32'h0,        0, 16, 1, 32'hFFFFFFFF};

    idle_inputs();
    bif.bus_ack = 0; bif.bus_rdata = 32'h0;
    last_rdata = 32'h0;

    // Reset with a load pending: stall must stay low and all outputs clear.
    reset = 1; cpu_rd = 1; cpu_addr = 32'h40;
    next_cycle();
    @(negedge clk);
    chk("rst stall",     32'(stall),       32'h0);
    chk("rst bus_req",   32'(bif.bus_req), 32'h0);
    chk("rst bus_addr",  bif.bus_addr,     32'h0);
    chk("rst bus_be",    32'(bif.bus_be),  32'h0);
    chk("rst cpu_rdata", cpu_rdata,        32'h0);
    chk("rst misalign",  32'(misalign),    32'h0);
    chk("rst bus_err",   32'(bus_err),     32'h0);
    next_cycle();
    reset = 0; idle_inputs();
    next_cycle();

    for (int i = 0; i < 11; i++) run_access($sformatf("vec%0d", i), tbl[i]);

    run_misalign("mis201", 32'h201);
    run_misalign("mis003", 32'h003);

    // Reset in the middle of a BUSY access, then a late ack that must be ignored.
    cpu_rd = 1; cpu_addr = 32'h80;
    repeat (3) next_cycle();
    reset = 1;
    @(negedge clk);
    chk("midrst stall_forced", 32'(stall), 32'h0);
    next_cycle();
    reset = 0; idle_inputs();
    @(negedge clk);
    chk("midrst bus_req", 32'(bif.bus_req), 32'h0);
    chk("midrst stall",   32'(stall),       32'h0);
    next_cycle();
    bif.bus_ack = 1; bif.bus_rdata = 32'hDEADBEEF;
    next_cycle();
    bif.bus_ack = 0;
    @(negedge clk);
    chk("lateack cpu_rdata", cpu_rdata,        32'h0);
    chk("lateack stall",     32'(stall),       32'h0);
    chk("lateack bus_err",   32'(bus_err),     32'h0);
    chk("lateack bus_req",   32'(bif.bus_req), 32'h0);
    last_rdata = 32'h0;
    next_cycle();

    // Randomized accesses against the model.
    for (int i = 0; i < 80; i++) begin
      vec_t v;
      int   kind = $urandom_range(0, 4);
      v = tbl[0];
      v.rd = (kind == 0) || (kind == 4);
      v.wr = (kind != 0);
      v.sb = (kind == 2) || ((kind == 4) && $urandom_range(0, 1) == 1);
      v.sh = (kind == 3) || ((kind == 4) && $urandom_range(0, 1) == 1);
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.resp  = $urandom;
      v.ack_at = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(0, TIMEOUT + 2);
      if (v.wr && v.sh && v.addr[0]) run_misalign($sformatf("rmis%0d", i), v.addr);
      else run_access($sformatf("rnd%0d", i), model(v, last_rdata));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
